// File: rtl/node_integrator.sv
// Serial node integrator: on each step, applies latched per-node forces to velocity (with damping)
// and then applies the new velocity to position, one node (both axes) per cycle.
module node_integrator #(
  parameter int unsigned NUM_NODES     = 10,
  parameter int unsigned POSITION_SIZE = 8,
  parameter int unsigned FORCE_SIZE    = 8,
  parameter int unsigned VEL_SIZE      = 8,
  parameter int unsigned FORCE_SHIFT   = 2,
  parameter int unsigned DAMP_SHIFT    = 3
) (
  input  logic                                          clk_in,
  input  logic                                          rst_in,
  input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] init_nodes_in,
  input  logic                                          begin_in,
  input  logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]    forces_in,
  output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_out,
  output logic [1:0][NUM_NODES-1:0][VEL_SIZE-1:0]      vels_out,
  output logic                                          busy_out,
  output logic                                          result_out
);

  localparam int unsigned IdxW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int unsigned VW   = VEL_SIZE + 2;
  localparam int unsigned PW   = ((POSITION_SIZE > VEL_SIZE) ? POSITION_SIZE : VEL_SIZE) + 2;

  localparam logic signed [VW-1:0] VMax = VW'((2 ** (VEL_SIZE - 1)) - 1);
  localparam logic signed [VW-1:0] VMin = ~VMax;
  localparam logic signed [PW-1:0] PMax = PW'((2 ** (POSITION_SIZE - 1)) - 1);
  localparam logic signed [PW-1:0] PMin = ~PMax;
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(NUM_NODES - 1);

  typedef enum logic [1:0] {StIdle, StUpdate, StDone} state_e;

  state_e                                        state_q, state_d;
  logic [IdxW-1:0]                               idx_q, idx_d;
  logic                                          latch;
  logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]    forces_q;
  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] nodes_q;
  logic [1:0][NUM_NODES-1:0][VEL_SIZE-1:0]      vels_q;

  logic signed [FORCE_SIZE-1:0]    f_raw [2];
  logic signed [VW-1:0]            v_ext [2];
  logic signed [VW-1:0]            f_ext [2];
  logic signed [VW-1:0]            v_sum [2];
  logic signed [VEL_SIZE-1:0]      vn    [2];
  logic signed [PW-1:0]            p_sum [2];
  logic signed [POSITION_SIZE-1:0] pn    [2];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (begin_in) begin
          state_d = StUpdate;
          idx_d   = '0;
          latch   = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StUpdate: begin
        if (idx_q == LastIdx) state_d = StDone;
        else                  idx_d   = idx_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Only node[idx_q] is computed; the result is written back only while in StUpdate.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      f_raw[a] = $signed(forces_q[a][idx_q]);
      f_ext[a] = VW'(f_raw[a]);
      f_ext[a] = f_ext[a] >>> FORCE_SHIFT;
      v_ext[a] = VW'($signed(vels_q[a][idx_q]));
      v_sum[a] = v_ext[a] - (v_ext[a] >>> DAMP_SHIFT) + f_ext[a];
      if (v_sum[a] > VMax)      vn[a] = VMax[VEL_SIZE-1:0];
      else if (v_sum[a] < VMin) vn[a] = VMin[VEL_SIZE-1:0];
      else                      vn[a] = v_sum[a][VEL_SIZE-1:0];
      p_sum[a] = PW'($signed(nodes_q[a][idx_q])) + PW'(vn[a]);
      if (p_sum[a] > PMax)      pn[a] = PMax[POSITION_SIZE-1:0];
      else if (p_sum[a] < PMin) pn[a] = PMin[POSITION_SIZE-1:0];
      else                      pn[a] = p_sum[a][POSITION_SIZE-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      forces_q <= '0;
      nodes_q  <= init_nodes_in;
      vels_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (latch) forces_q <= forces_in;
      if (state_q == StUpdate) begin
        for (int a = 0; a < 2; a++) begin
          nodes_q[a][idx_q] <= pn[a];
          vels_q[a][idx_q]  <= vn[a];
        end
      end
    end
  end

  assign nodes_out  = nodes_q;
  assign vels_out   = vels_q;
  assign busy_out   = (state_q == StUpdate);
  assign result_out = (state_q == StDone);

endmodule

// File: tb/tb_node_integrator.sv
// Directed bench for node_integrator: vector table of single-node steps plus hand-written
// sequences for back-to-back starts, mid-step disturbance, saturation and mid-step reset.
module tb_node_integrator;

  localparam int N = 10;
  typedef logic [1:0][N-1:0][7:0] arr_t;

  typedef struct {
    int node;
    int fx;
    int fy;
    int vx;
    int vy;
    int px;
    int py;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic begin_in = 1'b0;
  arr_t init_nodes_in = '0;
  arr_t forces_in = '0;
  arr_t nodes_out;
  arr_t vels_out;
  logic busy_out;
  logic result_out;

  int n_cmp = 0;
  int n_bad = 0;
  int m_p[2][N];
  int m_v[2][N];
  arr_t cur_f;
  vec_t tbl[5];

  node_integrator dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .init_nodes_in(init_nodes_in),
    .begin_in     (begin_in),
    .forces_in    (forces_in),
    .nodes_out    (nodes_out),
    .vels_out     (vels_out),
    .busy_out     (busy_out),
    .result_out   (result_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input arr_t act, input arr_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int clamp8(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 2; a++)
      for (int i = 0; i < N; i++) begin
        m_p[a][i] = int'($signed(init_nodes_in[a][i]));
        m_v[a][i] = 0;
      end
  endtask

  task automatic model_step(input arr_t f);
    for (int a = 0; a < 2; a++)
      for (int i = 0; i < N; i++) begin
        int fi = int'($signed(f[a][i]));
        m_v[a][i] = clamp8(m_v[a][i] - (m_v[a][i] >>> 3) + (fi >>> 2));
        m_p[a][i] = clamp8(m_p[a][i] + m_v[a][i]);
      end
  endtask

  function automatic arr_t pack_model(input bit vel);
    arr_t r;
    for (int a = 0; a < 2; a++)
      for (int i = 0; i < N; i++) r[a][i] = vel ? 8'(m_v[a][i]) : 8'(m_p[a][i]);
    return r;
  endfunction

  task automatic do_reset();
    begin_in  = 1'b0;
    forces_in = '0;
    rst_in    = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic launch(input arr_t f);
    forces_in = f;
    begin_in  = 1'b1;
    cur_f     = f;
  endtask

  // Completes a step already launched; forces_in is scrambled after accept to prove latching.
  task automatic finish_step(input string nm, input bit disturb, input bit chain, input arr_t nf);
    int  busy_cnt = 0;
    bit  got = 1'b0;
    @(posedge clk_in);
    #1;
    begin_in = 1'b0;
    for (int a = 0; a < 2; a++)
      for (int i = 0; i < N; i++) forces_in[a][i] = 8'($urandom);
    for (int c = 0; c < 20 && !got; c++) begin
      if (result_out) got = 1'b1;
      else begin
        if (busy_out) busy_cnt++;
        if (disturb) begin_in = (c == 3);
        @(posedge clk_in);
        #1;
      end
    end
    begin_in = 1'b0;
    check_int({nm, " result_seen"}, int'(got), 1);
    check_int({nm, " busy_cycles"}, busy_cnt, N);
    check_int({nm, " busy_at_done"}, int'(busy_out), 0);
    model_step(cur_f);
    check_vec({nm, " nodes"}, nodes_out, pack_model(1'b0));
    check_vec({nm, " vels"}, vels_out, pack_model(1'b1));
    if (chain) begin
      launch(nf);
    end else begin
      @(posedge clk_in);
      #1;
      check_int({nm, " result_one_cycle"}, int'(result_out), 0);
      check_int({nm, " idle_after"}, int'(busy_out), 0);
    end
  endtask

  task automatic run_step(input string nm, input arr_t f);
    launch(f);
    finish_step(nm, 1'b0, 1'b0, '0);
  endtask

  initial begin
    arr_t f;
    arr_t f2;
    arr_t std_init;
    int   extra;

    tbl[0] = '{3, 16, 0, 4, 0, 7, -3};
    tbl[1] = '{3, 16, 0, 8, 0, 15, -3};
    tbl[2] = '{3, 0, -16, 7, -4, 22, -7};
    tbl[3] = '{3, 0, 0, 7, -3, 29, -10};
    tbl[4] = '{9, -128, 127, -32, 31, -23, 22};

    for (int i = 0; i < N; i++) begin
      std_init[0][i] = 8'(i);
      std_init[1][i] = 8'(-i);
    end
    init_nodes_in = std_init;

    // Reset state
    do_reset();
    check_vec("reset nodes", nodes_out, std_init);
    check_vec("reset vels", vels_out, '0);
    check_int("reset busy", int'(busy_out), 0);
    check_int("reset result", int'(result_out), 0);

    // Zero force step leaves positions alone
    run_step("zero_step", '0);
    check_vec("zero_step positions", nodes_out, std_init);

    // Single-node vectors, state carries from one to the next
    for (int k = 0; k < 5; k++) begin
      f = '0;
      f[0][tbl[k].node] = 8'(tbl[k].fx);
      f[1][tbl[k].node] = 8'(tbl[k].fy);
      run_step($sformatf("vec%0d", k), f);
      check_int($sformatf("vec%0d vx", k), int'($signed(vels_out[0][tbl[k].node])), tbl[k].vx);
      check_int($sformatf("vec%0d vy", k), int'($signed(vels_out[1][tbl[k].node])), tbl[k].vy);
      check_int($sformatf("vec%0d px", k), int'($signed(nodes_out[0][tbl[k].node])), tbl[k].px);
      check_int($sformatf("vec%0d py", k), int'($signed(nodes_out[1][tbl[k].node])), tbl[k].py);
    end

    // Back-to-back: begin_in asserted during DONE starts the next step immediately
    f = '0;
    f[0][1] = 8'sd40;
    f2 = '0;
    f2[1][6] = -8'sd20;
    launch(f);
    finish_step("chain_a", 1'b0, 1'b1, f2);
    finish_step("chain_b", 1'b0, 1'b0, '0);

    // begin_in during UPDATE ignored; forces changed mid-step ignored
    f = '0;
    f[0][2] = 8'sd8;
    launch(f);
    finish_step("disturb", 1'b1, 1'b0, '0);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_in);
      #1;
      if (result_out || busy_out) extra++;
    end
    check_int("disturb no_second_step", extra, 0);

    // Saturation on both axes from positions near the rails
    init_nodes_in = std_init;
    init_nodes_in[0][0] = 8'sd100;
    init_nodes_in[1][0] = -8'sd100;
    do_reset();
    f = '0;
    f[0][0] = 8'sd127;
    f[1][0] = -8'sd128;
    for (int s = 0; s < 7; s++) begin
      run_step($sformatf("sat%0d", s), f);
      if (s == 0) begin
        check_int("sat0 vx", int'($signed(vels_out[0][0])), 31);
        check_int("sat0 vy", int'($signed(vels_out[1][0])), -32);
        check_int("sat0 px", int'($signed(nodes_out[0][0])), 127);
        check_int("sat0 py", int'($signed(nodes_out[1][0])), -128);
      end
    end
    check_int("sat6 vx", int'($signed(vels_out[0][0])), 127);
    check_int("sat6 vy", int'($signed(vels_out[1][0])), -128);
    check_int("sat6 px", int'($signed(nodes_out[0][0])), 127);
    check_int("sat6 py", int'($signed(nodes_out[1][0])), -128);

    // Reset on the edge that would update node 5
    init_nodes_in = std_init;
    f = '0;
    for (int i = 0; i < N; i++) f[0][i] = 8'sd64;
    launch(f);
    @(posedge clk_in);
    #1;
    begin_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    check_int("midrst partial_update", int'($signed(nodes_out[0][4])), 4 + 16);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    model_reset();
    check_vec("midrst nodes", nodes_out, std_init);
    check_vec("midrst vels", vels_out, '0);
    check_int("midrst busy", int'(busy_out), 0);
    check_int("midrst result", int'(result_out), 0);
    extra = 0;
    for (int c = 0; c < N + 3; c++) begin
      @(posedge clk_in);
      #1;
      if (result_out || busy_out) extra++;
    end
    check_int("midrst stays_idle", extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
